rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised N-channel, WIDTH-bit registered arbitrating multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the 4:1 combinational mux. Adds a selectable arbitration mode (round-robin, fixed-priority, forced-select), a one-entry output register, and a channel-ID tag.
- Sits between multiple producers (for example, register-file read ports or lab peripherals) and a single shared consumer.

Parameters:
- N_CH, 4, number of input channels (2..16).
- WIDTH, 32, data width per channel.
- CNT_W, 16, width of per-channel grant counters (used only with ARB_STATS_EN).
- SEL_W, derived localparam = $clog2(N_CH), width of the channel index.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  arbitration mode: 00 RR, 01 FIXED, 10 FORCED, 11 reserved (behaves as RR)
- sel  in  SEL_W  channel index used in FORCED mode
- in_valid  in  N_CH  per-channel valid
- in_data  in  N_CH*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  N_CH  per-channel ready (combinational)
- out_valid  out  1  output register holds data
- out_ready  in  1  consumer accepts
- out_data  out  WIDTH  registered data
- out_chan  out  SEL_W  index of the channel that supplied out_data
- grant_cnt  out  N_CH*CNT_W  per-channel accepted-transfer counters (ARB_STATS_EN only)
- cnt_clr  in  1  synchronous clear of grant_cnt (ARB_STATS_EN only)

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_chan=0, RR pointer ptr=0, grant_cnt=0. in_ready=0 while rst_n=0.
- Output register FSM:
  - States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - load_en = EMPTY | out_ready.
  - EMPTY: goes to FULL on any accept.
  - FULL: out_ready=1 with an accept stays FULL and loads the new data (full throughput). out_ready=1 without an accept goes to EMPTY. out_ready=0 stays FULL with out_data and out_chan held stable.
- Arbitration is combinational over in_valid and produces a one-hot grant (at most one bit set):
  - RR: the first valid channel searching ptr, ptr+1, … modulo N_CH.
  - FIXED: the lowest-index valid channel.
  - FORCED: only channel sel, and only if in_valid[sel]. If sel >= N_CH, no grant.
- in_ready = grant & {N_CH{load_en}}. An accept on channel i is in_valid[i] & in_ready[i].
- Latency: data accepted in cycle t appears on out_data and out_valid in cycle t+1.
- Pointer update:
  - In RR mode only, on an accept from channel k: ptr <= (k == N_CH-1) ? 0 : k+1 (wrap-around).
  - No accept leaves ptr unchanged.
  - FIXED and FORCED modes do not modify ptr.
- Mode or sel changes take effect in the same cycle's arbitration. Data already held in the output register is unaffected.
- A channel that is not granted sees in_ready=0 and must hold its data (standard valid/ready; the block never drops data).
- All-invalid inputs produce no grant and no state change except draining the output.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - grant_cnt and cnt_clr ports exist.
  - grant_cnt[i] increments by 1 on each accept from channel i and saturates at 2^CNT_W-1.
  - cnt_clr=1 zeroes all counters synchronously. If cnt_clr and an accept occur in the same cycle, clear wins.
  - Counters reset to 0.
- Undefined: the ports and counters are absent. Datapath and arbitration behaviour are identical.

Decomposition:
- Package rr_arb_pkg:
  - mode encodings MODE_RR=2'b00, MODE_FIXED=2'b01, MODE_FORCED=2'b10.
  - state encodings ST_EMPTY and ST_FULL.
- Sub-module rr_arbiter: owns the ptr register and produces the combinational one-hot grant from in_valid, mode, sel and the accept strobe. The top level holds the output register, muxing and counters.

Test Plan:
- RR fairness: N_CH=4, mode=00, in_valid=4'b1111 held, out_ready=1, data i = 32'hA0+i → out_chan sequence 0,1,2,3,0 with one output per cycle and out_data matching.
- FIXED priority: mode=01, in_valid=4'b1010 → channel 1 granted every cycle. Drop in_valid[1] → channel 3 granted next.
- FORCED and out-of-range: mode=10, sel=2, in_valid=4'b0100, in_data[2]=32'hDEADBEEF → out_data=32'hDEADBEEF, out_chan=2 one cycle later. Then sel=2 with in_valid=4'b1011 → no grant and out_valid falls.
- Backpressure: FULL with out_ready=0 for 5 cycles → in_ready=0000, out_data stable. Raise out_ready → held word consumed, next grant loaded the same cycle.
- Reset mid-transfer: assert rst_n=0 asynchronously while out_valid=1 → out_valid, out_data and out_chan go to 0 immediately. After release, RR restarts from channel 0.
- ARB_STATS_EN: 3 accepts from channel 0, 2 from channel 3 → grant_cnt[0]=3, grant_cnt[3]=2. cnt_clr coinciding with an accept → counter reads 0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared encodings for the rr_arb_mux arbitrating multiplexer.
package rr_arb_pkg;

  // Arbitration mode encodings; the reserved code behaves as round-robin.
  localparam logic [1:0] MODE_RR     = 2'b00;
  localparam logic [1:0] MODE_FIXED  = 2'b01;
  localparam logic [1:0] MODE_FORCED = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter with a round-robin pointer register.
// Modes: round-robin from ptr, lowest-index fixed priority, forced select.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic [N_CH-1:0]  in_valid,
  input  logic [N_CH-1:0]  accept,
  output logic [N_CH-1:0]  grant
);

  logic [SEL_W-1:0] ptr_reg;
  logic [SEL_W-1:0] ptr_next;
  logic [N_CH-1:0]  rr_grant;
  logic [N_CH-1:0]  fixed_grant;
  logic [N_CH-1:0]  forced_grant;
  logic             rr_found;
  logic [SEL_W:0]   rr_sum;
  logic [SEL_W-1:0] rr_idx;
  logic             is_rr;

  assign is_rr = (mode == MODE_RR) || (mode == MODE_RSVD);

  // Round-robin: first valid channel searching ptr, ptr+1, ... modulo N_CH.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    rr_sum   = '0;
    rr_idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      rr_sum = {1'b0, ptr_reg} + (SEL_W+1)'(k);
      if (rr_sum >= (SEL_W+1)'(N_CH)) begin
        rr_sum = rr_sum - (SEL_W+1)'(N_CH);
      end
      rr_idx = rr_sum[SEL_W-1:0];
      if (!rr_found && in_valid[rr_idx]) begin
        rr_grant[rr_idx] = 1'b1;
        rr_found         = 1'b1;
      end
    end
  end

  // Fixed priority: isolate the lowest set bit of in_valid.
  assign fixed_grant = in_valid & (~in_valid + N_CH'(1));

  // Forced select: an out-of-range sel matches no channel, so no grant.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_forced
    assign forced_grant[gi] = in_valid[gi] && (sel == SEL_W'(gi));
  end

  // Mode steering of the grant vector.
  always_comb begin
    grant = '0;
    case (mode)
      MODE_FIXED:  grant = fixed_grant;
      MODE_FORCED: grant = forced_grant;
      default:     grant = rr_grant;
    endcase
  end

  // Pointer advances past the accepted channel, only in round-robin mode.
  always_comb begin
    ptr_next = ptr_reg;
    if (is_rr) begin
      for (int k = 0; k < N_CH; k++) begin
        if (accept[k]) begin
          ptr_next = (k == N_CH-1) ? '0 : SEL_W'(k + 1);
        end
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel registered arbitrating multiplexer with valid/ready handshakes.
// Optional per-channel grant counters are built when ARB_STATS_EN is defined.
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter int  N_CH  = 4,
  parameter int  WIDTH = 32,
  parameter int  CNT_W = 16,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_chan
`ifdef ARB_STATS_EN
  ,
  output logic [N_CH*CNT_W-1:0] grant_cnt,
  input  logic                  cnt_clr
`endif
);

  state_t           state_reg;
  state_t           state_next;
  logic             load_en;
  logic [N_CH-1:0]  grant;
  logic [N_CH-1:0]  accept;
  logic             any_accept;
  logic [WIDTH-1:0] data_sel;
  logic [SEL_W-1:0] chan_sel;
  logic [WIDTH-1:0] out_data_reg;
  logic [SEL_W-1:0] out_chan_reg;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel      (sel),
    .in_valid (in_valid),
    .accept   (accept),
    .grant    (grant)
  );

  // The output register can take a word when empty or when it is being drained.
  assign load_en    = (state_reg == ST_EMPTY) || out_ready;
  assign in_ready   = grant & {N_CH{load_en && rst_n}};
  assign accept     = in_valid & in_ready;
  assign any_accept = |accept;

  // Select the accepted channel's data and index (accept is one-hot).
  always_comb begin
    data_sel = '0;
    chan_sel = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (accept[k]) begin
        data_sel = in_data[k*WIDTH +: WIDTH];
        chan_sel = SEL_W'(k);
      end
    end
  end

  // Output occupancy next state.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: if (any_accept) state_next = ST_FULL;
      ST_FULL:  if (out_ready && !any_accept) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Output data/channel register; holds while stalled or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg <= '0;
      out_chan_reg <= '0;
    end else if (any_accept) begin
      out_data_reg <= data_sel;
      out_chan_reg <= chan_sel;
    end
  end

  assign out_valid = (state_reg == ST_FULL);
  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;

`ifdef ARB_STATS_EN
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    // Saturating accept counter; clear has priority over an increment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (cnt_clr) begin
        cnt_reg <= '0;
      end else if (accept[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end

    assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (N_CH=4, WIDTH=32).
module tb_rr_arb_mux;

  localparam int N_CH  = 4;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            mode;
  logic [1:0]            sel;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [1:0]            out_chan;
`ifdef ARB_STATS_EN
  logic [N_CH*CNT_W-1:0] grant_cnt;
  logic                  cnt_clr;
`endif

  int n_cmp;
  int n_err;

  rr_arb_mux #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .cnt_clr   (cnt_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data(input int ch, input logic [31:0] v);
    in_data[ch*WIDTH +: WIDTH] = v;
  endtask

  task automatic check_out(input string tag, input logic [1:0] ch, input logic [31:0] d);
    check({tag, ".valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, ".chan"}, 64'(out_chan), 64'(ch));
    check({tag, ".data"}, 64'(out_data), 64'(d));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    mode      = 2'b00;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef ARB_STATS_EN
    cnt_clr   = 1'b0;
`endif
    for (int i = 0; i < N_CH; i++) set_data(i, 32'hA0 + 32'(i));

    // Reset state, with all inputs valid.
    #1;
    check("rst.in_ready", 64'(in_ready), 64'(4'b0000));
    check("rst.out_valid", 64'(out_valid), 64'(1'b0));
    check("rst.out_data", 64'(out_data), 64'(32'h0));
    check("rst.out_chan", 64'(out_chan), 64'(2'd0));
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Round-robin fairness: 0,1,2,3,0.
    check("rr.in_ready0", 64'(in_ready), 64'(4'b0001));
    for (int j = 0; j < 5; j++) begin
      tick();
      check_out($sformatf("rr.%0d", j), 2'(j % 4), 32'hA0 + 32'(j % 4));
    end

    // Fixed priority: channel 1 wins over 3 until it drops.
    mode     = 2'b01;
    in_valid = 4'b1010;
    #1;
    check("fix.in_ready", 64'(in_ready), 64'(4'b0010));
    tick();
    check_out("fix.a", 2'd1, 32'hA1);
    tick();
    check_out("fix.b", 2'd1, 32'hA1);
    in_valid = 4'b1000;
    #1;
    check("fix.in_ready3", 64'(in_ready), 64'(4'b1000));
    tick();
    check_out("fix.c", 2'd3, 32'hA3);

    // Forced select.
    mode     = 2'b10;
    sel      = 2'd2;
    in_valid = 4'b0100;
    set_data(2, 32'hDEADBEEF);
    #1;
    check("frc.in_ready", 64'(in_ready), 64'(4'b0100));
    tick();
    check_out("frc.a", 2'd2, 32'hDEADBEEF);
    in_valid = 4'b1011;
    #1;
    check("frc.no_grant", 64'(in_ready), 64'(4'b0000));
    tick();
    check("frc.out_valid", 64'(out_valid), 64'(1'b0));

    // Backpressure: output held for 5 stalled cycles.
    mode     = 2'b01;
    in_valid = 4'b0001;
    set_data(0, 32'h11);
    tick();
    check_out("bp.load", 2'd0, 32'h11);
    out_ready = 1'b0;
    set_data(0, 32'h22);
    in_valid  = 4'b0011;
    for (int j = 0; j < 5; j++) begin
      #1;
      check($sformatf("bp.in_ready%0d", j), 64'(in_ready), 64'(4'b0000));
      tick();
      check_out($sformatf("bp.hold%0d", j), 2'd0, 32'h11);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 64'(in_ready), 64'(4'b0001));
    tick();
    check_out("bp.next", 2'd0, 32'h22);

    // Asynchronous reset while the output register is full.
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 64'(out_valid), 64'(1'b0));
    check("arst.out_data", 64'(out_data), 64'(32'h0));
    check("arst.out_chan", 64'(out_chan), 64'(2'd0));
    check("arst.in_ready", 64'(in_ready), 64'(4'b0000));
    tick();
    rst_n    = 1'b1;
    mode     = 2'b00;
    in_valid = 4'b1111;
    set_data(0, 32'hA0);
    set_data(2, 32'hA2);
    #1;
    check("arst.rr_ready", 64'(in_ready), 64'(4'b0001));
    tick();
    check_out("arst.rr0", 2'd0, 32'hA0);
    tick();
    check_out("arst.rr1", 2'd1, 32'hA1);

`ifdef ARB_STATS_EN
    // Grant counters: clear, 3 accepts on ch0, 2 on ch3, then clear vs accept.
    in_valid = 4'b0000;
    cnt_clr  = 1'b1;
    tick();
    cnt_clr  = 1'b0;
    mode     = 2'b01;
    in_valid = 4'b0001;
    repeat (3) tick();
    in_valid = 4'b1000;
    repeat (2) tick();
    in_valid = 4'b0000;
    tick();
    check("cnt.ch0", 64'(grant_cnt[0*CNT_W +: CNT_W]), 64'(16'd3));
    check("cnt.ch3", 64'(grant_cnt[3*CNT_W +: CNT_W]), 64'(16'd2));
    check("cnt.ch1", 64'(grant_cnt[1*CNT_W +: CNT_W]), 64'(16'd0));
    in_valid = 4'b0001;
    cnt_clr  = 1'b1;
    tick();
    cnt_clr  = 1'b0;
    in_valid = 4'b0000;
    check_out("cnt.clr_accept", 2'd0, 32'hA0);
    check("cnt.clr_wins", 64'(grant_cnt[0*CNT_W +: CNT_W]), 64'(16'd0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
